// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB,
    EXT_LOCK
  } fsm_e;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_CPU,
    RD_EXT
  } rd_owner_e;

  // Width of the starvation counter; at least one bit so MAX_WAIT=0 still elaborates.
  function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
    return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational priority/grant logic for the data-memory port arbiter.
import dmem_arb_pkg::*;

module dmem_arb_grant #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = wait_cnt_w(MAX_WAIT)
) (
  input  logic             i_rst,
  input  fsm_e             i_state,
  input  logic [CNT_W-1:0] i_wait_cnt,
  input  logic             i_cpu_req,
  input  logic             i_ext_req,
  output logic             o_cpu_gnt,
  output logic             o_ext_gnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic w_ext_wins;

  // Ext wins when alone, when locked, or once it has waited MAX_WAIT cycles; CPU otherwise.
  always_comb begin
    o_cpu_gnt  = 1'b0;
    o_ext_gnt  = 1'b0;
    w_ext_wins = i_ext_req &&
                 (!i_cpu_req || (i_state == EXT_LOCK) || (i_wait_cnt == MAX_CNT));
    if (!i_rst) begin
      if (w_ext_wins)     o_ext_gnt = 1'b1;
      else if (i_cpu_req) o_cpu_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data sram port between the CPU MEM stage and an external master.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
import dmem_arb_pkg::*;

module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  localparam int unsigned      CNT_W   = wait_cnt_w(MAX_WAIT);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  fsm_e             r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  rd_owner_e        r_rd_owner;

  dmem_arb_grant #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_grant (
    .i_rst      (rst),
    .i_state    (r_state),
    .i_wait_cnt (r_wait_cnt),
    .i_cpu_req  (cpu_req),
    .i_ext_req  (ext_req),
    .o_cpu_gnt  (cpu_gnt),
    .o_ext_gnt  (ext_gnt)
  );

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Route the granted requester's fields to the sram; CPU fields when idle.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wen   = cpu_gnt & cpu_wen;
    mem_ren   = cpu_gnt & ~cpu_wen;
    if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end
  end

  // Lock FSM, starvation counter and read-return owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_wait_cnt <= '0;
      r_rd_owner <= RD_NONE;
    end else begin
      case (r_state)
        ARB:      if (ext_gnt && ext_lock) r_state <= EXT_LOCK;
        EXT_LOCK: if ((ext_gnt && !ext_lock) || !ext_req) r_state <= ARB;
        default:  r_state <= ARB;
      endcase

      if (!ext_req || ext_gnt)      r_wait_cnt <= '0;
      else if (r_wait_cnt != MAX_CNT) r_wait_cnt <= r_wait_cnt + 1'b1;

      if (cpu_gnt && !cpu_wen)      r_rd_owner <= RD_CPU;
      else if (ext_gnt && !ext_wen) r_rd_owner <= RD_EXT;
      else                          r_rd_owner <= RD_NONE;
    end
  end

  // Gated by rst so a read pending across reset is dropped immediately.
  assign cpu_rvalid = ~rst & (r_rd_owner == RD_CPU);
  assign ext_rvalid = ~rst & (r_rd_owner == RD_EXT);
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_conflict;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall    <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (cpu_stall && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (cpu_req && ext_req && (r_perf_conflict != '1))
        r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_stall_cnt    = r_perf_stall;
  assign perf_conflict_cnt = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: the driver queues expected grants and
// read data, an independent monitor compares whenever the DUT presents them.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_wen = 1'b0, ext_req = 1'b0, ext_wen = 1'b0, ext_lock = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_wen, mem_ren;
  logic [63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_conflict_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        cg, eg, st, mw, mr;
    logic [63:0] ma, md;
  } gexp_t;

  gexp_t       g_q[$];
  logic [63:0] cpu_q[$];
  logic [63:0] ext_q[$];

  dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read sram model, 128 x 64-bit words.
  logic [63:0] sram [0:127];
  initial begin
    for (int i = 0; i < 128; i++) sram[i] = '0;
    sram[7'h02] = 64'hDEADBEEF;  // address 0x10
  end
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[9:3]] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr[9:3]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus plus the expected grant outcome for that cycle.
  task automatic step(input logic r, input logic cr, input logic cw,
                      input logic [63:0] ca, input logic [63:0] cd,
                      input logic er, input logic ew,
                      input logic [63:0] ea, input logic [63:0] ed, input logic el,
                      input logic gc, input logic ge);
    gexp_t g;
    @(posedge clk);
    #1;
    rst = r; cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed; ext_lock = el;
    g.cg = gc; g.eg = ge; g.st = cr & ~gc;
    g.mw = (gc & cw) | (ge & ew);
    g.mr = (gc & ~cw) | (ge & ~ew);
    g.ma = ge ? ea : ca;
    g.md = ge ? ed : cd;
    g_q.push_back(g);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare grants every driven cycle, read data whenever an rvalid appears.
  always @(negedge clk) begin
    if (g_q.size() > 0) begin
      gexp_t g;
      g = g_q.pop_front();
      chk("cpu_gnt", 64'(cpu_gnt), 64'(g.cg));
      chk("ext_gnt", 64'(ext_gnt), 64'(g.eg));
      chk("cpu_stall", 64'(cpu_stall), 64'(g.st));
      chk("mem_wen", 64'(mem_wen), 64'(g.mw));
      chk("mem_ren", 64'(mem_ren), 64'(g.mr));
      if (g.cg || g.eg) chk("mem_addr", mem_addr, g.ma);
      if (g.mw) chk("mem_wdata", mem_wdata, g.md);
    end
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 64'd1, 64'd0);
      else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (ext_rvalid) begin
      if (ext_q.size() == 0) chk("ext_rvalid_unexpected", 64'd1, 64'd0);
      else chk("ext_rdata", ext_rdata, ext_q.pop_front());
    end
  end

  initial begin
    // Reset with a CPU read pending: no grant, stall follows request.
    step(1'b1, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    // Released: CPU read of 0x10 granted immediately.
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'hDEADBEEF);
    idle();

    // Continuous conflict: CPU wins 4 cycles, ext forced through on the 5th.
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b1, 1'b0);
      cpu_q.push_back(64'hDEADBEEF);
    end
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, 1'b1);
    ext_q.push_back(64'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'hDEADBEEF);
    idle();

    // Locked burst: ext write to 0x20 waits out the CPU, then holds the port for 3 writes.
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b1, 64'h20, 64'hA0, 1'b1, 1'b1, 1'b0);
      cpu_q.push_back(64'hDEADBEEF);
    end
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b1, 64'h20, 64'hA0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b1, 64'h28, 64'hA8, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b1, 64'h30, 64'hB0, 1'b0, 1'b0, 1'b1);
    // Lock released: CPU reads back the middle burst word.
    step(1'b0, 1'b1, 1'b0, 64'h28, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'hA8);
    // ARB again: a single unlocked conflict cycle goes to the CPU.
    step(1'b0, 1'b1, 1'b0, 64'h30, '0, 1'b1, 1'b0, 64'h20, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'hB0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 64'h20, '0, 1'b0, 1'b0, 1'b1);
    ext_q.push_back(64'hA0);
    idle();

    // Same-address ordering in both directions.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 64'h40, 64'h55, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 64'h40, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'h55);
    step(1'b0, 1'b1, 1'b1, 64'h48, 64'h77, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 64'h48, '0, 1'b0, 1'b0, 1'b1);
    ext_q.push_back(64'h77);

    // Back-to-back reads alternating owners.
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'hDEADBEEF);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 64'h40, '0, 1'b0, 1'b0, 1'b1);
    ext_q.push_back(64'h55);
    step(1'b0, 1'b1, 1'b0, 64'h28, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cpu_q.push_back(64'hA8);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 64'h30, '0, 1'b0, 1'b0, 1'b1);
    ext_q.push_back(64'hB0);
    idle();

    // Reset the cycle after a granted CPU read: that rvalid must never appear.
    step(1'b0, 1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle();
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'd0);
    chk("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'd0);
`endif
    idle();
    idle();
    @(posedge clk);
    #1;
    chk("cpu_reads_outstanding", 64'(cpu_q.size()), 64'd0);
    chk("ext_reads_outstanding", 64'(ext_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (64-bit data sram) between two requesters: the CPU MEM stage and an external master (loader/debug/DMA).
- Arbitrates per cycle, stalls the CPU pipeline on loss, bounds external starvation, supports locked external bursts, and routes synchronous read data back to its owner.
- Sits between the MEM pipeline stage and the data sram's internal port.

Parameters:
- ADDR_W, 64, address width of both requesters and memory.
- DATA_W, 64, data width.
- MAX_WAIT, 4, max consecutive cycles ext_req may lose to the CPU before it is forced through; 0 = ext wins every conflict.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request (MEM-stage read or write)
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & !cpu_gnt; freezes the pipeline
- cpu_rvalid  out  1  CPU read data valid (cycle after granted read)
- cpu_rdata  out  DATA_W  CPU read data
- ext_req, ext_wen, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external request, same meaning
- ext_lock  in  1  keep ext ownership after this grant
- ext_gnt  out  1  ext access performed this cycle
- ext_rvalid  out  1  ext read data valid
- ext_rdata  out  DATA_W  ext read data
- mem_addr  out  ADDR_W  to sram
- mem_wen  out  1  to sram
- mem_ren  out  1  to sram
- mem_wdata  out  DATA_W  to sram
- mem_rdata  in  DATA_W  from sram, valid one cycle after mem_ren

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- State: fsm {ARB, EXT_LOCK}; wait_cnt [$clog2(MAX_WAIT+1)-1:0]; rd_owner {NONE, CPU, EXT}.
- Reset values: fsm=ARB, wait_cnt=0, rd_owner=NONE. While rst=1: cpu_gnt=ext_gnt=0, mem_wen=mem_ren=0, cpu_rvalid=ext_rvalid=0, cpu_stall=cpu_req.
- Grant is combinational, same cycle. A transfer occurs when req & gnt. At most one grant per cycle.
- ARB state:
  - Only one request present: that requester is granted.
  - Both present: CPU wins unless wait_cnt==MAX_WAIT, in which case ext wins.
- EXT_LOCK state: ext always wins while ext_req=1.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle ext_req=1 and ext_gnt=0.
  - Clears on ext_gnt or when ext_req=0.
- fsm transitions:
  - ARB -> EXT_LOCK on ext_gnt & ext_lock.
  - EXT_LOCK -> ARB on (ext_gnt & !ext_lock) or ext_req=0.
- mem_* outputs:
  - mem_* is a mux of the granted requester's fields.
  - mem_wen = gnt & wen; mem_ren = gnt & !wen.
  - No grant: mem_wen=mem_ren=0; mem_addr/mem_wdata don't-care (drive CPU fields).
- Read return: rd_owner is registered from the granted read, so latency is exactly 1 cycle.
  - cpu_rvalid = (rd_owner==CPU); ext_rvalid = (rd_owner==EXT).
  - cpu_rdata = ext_rdata = mem_rdata unqualified; consumers use rvalid.
  - Back-to-back reads from alternating owners are supported every cycle.
- Writes produce no response; a write is complete at grant.
- Same-address conflict: accesses are serialized in grant order. A read granted after a write sees the written data.
- A requester must hold its request and fields stable until granted.
- Reset mid-operation: a pending rvalid is dropped; any lock is released.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt[31:0]: cycles with cpu_stall=1.
  - Adds output perf_conflict_cnt[31:0]: cycles with cpu_req & ext_req.
  - Both reset to 0 on rst and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (dmem_arb_pkg):
  - fsm state enum {ARB, EXT_LOCK}.
  - rd_owner enum {NONE, CPU, EXT}.
  - Counter width function/constant.
- Natural sub-module: dmem_arb_grant, the combinational priority/grant logic, taking state and wait_cnt. Everything else stays in the top.

Test Plan:
- Reset: assert rst with cpu_req=1 -> cpu_gnt=0, cpu_stall=1, mem_wen=mem_ren=0. Deassert -> next cycle cpu_gnt=1.
- CPU read alone, addr 0x10 holding 0xDEADBEEF -> mem_ren=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, ext_rvalid=0.
- Continuous conflict, MAX_WAIT=4:
  - Cycles 0-3: cpu_gnt=1.
  - Cycle 4: ext_gnt=1 and cpu_stall=1.
  - Cycle 5: cpu_gnt=1 again, wait_cnt=0.
- Locked burst: ext writes 0x20, 0x28, 0x30 with ext_lock=1,1,0 while cpu_req=1 -> ext_gnt 3 consecutive cycles, cpu_stall=1 throughout; then cpu_gnt=1, fsm=ARB.
- Ordering on the same address:
  - Ext write 0x55 to 0x40, then CPU read 0x40 next cycle -> CPU reads 0x55.
  - Alternating reads -> rvalid lands on the correct owner each cycle.
- Reset during a pending CPU read (rst in cycle after grant) -> cpu_rvalid=0; with DMEM_ARB_PERF_EN, perf counters read 0.
